// File: rtl/operand_fetch_pkg.sv
// Shared opcodes, instruction field positions and opcode-class decode for operand_fetch.
package operand_fetch_pkg;

  localparam logic [5:0] OP_NOP    = 6'h00;
  localparam logic [5:0] OP_ALU    = 6'h01;
  localparam logic [5:0] OP_ALUI   = 6'h02;
  localparam logic [5:0] OP_LOAD   = 6'h03;
  localparam logic [5:0] OP_STORE  = 6'h04;
  localparam logic [5:0] OP_BRANCH = 6'h05;

  localparam int OP_LO  = 26;
  localparam int RD_LO  = 20;
  localparam int RS1_LO = 14;
  localparam int RS2_LO = 8;
  localparam int IMM_W  = 14;

  typedef struct packed {
    logic known;
    logic use1;
    logic use2;
    logic wr;
  } op_class_t;

  function automatic op_class_t decode_class(input logic [5:0] op);
    op_class_t c;
    c = '0;
    case (op)
      OP_ALU:    c = '{known: 1'b1, use1: 1'b1, use2: 1'b1, wr: 1'b1};
      OP_ALUI:   c = '{known: 1'b1, use1: 1'b1, use2: 1'b0, wr: 1'b1};
      OP_LOAD:   c = '{known: 1'b1, use1: 1'b1, use2: 1'b0, wr: 1'b1};
      OP_STORE:  c = '{known: 1'b1, use1: 1'b1, use2: 1'b1, wr: 1'b0};
      OP_BRANCH: c = '{known: 1'b1, use1: 1'b1, use2: 1'b1, wr: 1'b0};
      OP_NOP:    c = '{known: 1'b1, use1: 1'b0, use2: 1'b0, wr: 1'b0};
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Instruction, regfile, writeback and operand-bundle signals of the issue stage.
interface operand_fetch_if #(parameter int AW = 6, parameter int DW = 32);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_instr;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic [DW-1:0] reg1;
  logic [DW-1:0] reg2;
  logic          wb_we;
  logic [AW-1:0] wb_wa;
  logic [DW-1:0] wb_wd;
  logic          out_valid;
  logic          out_ready;
  logic [5:0]    out_op;
  logic [AW-1:0] out_rd;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic [DW-1:0] out_imm;

  modport slave (
    input  in_valid, in_instr, reg1, reg2, wb_we, wb_wa, wb_wd, out_ready,
    output in_ready, addr1, addr2, out_valid, out_op, out_rd, out_a, out_b, out_imm
  );

  modport master (
    output in_valid, in_instr, reg1, reg2, wb_we, wb_wa, wb_wd, out_ready,
    input  in_ready, addr1, addr2, out_valid, out_op, out_rd, out_a, out_b, out_imm
  );
endinterface

// File: rtl/operand_fetch_scoreboard.sv
// In-flight destination tracker: one busy bit per register, set beats clear on the same index.
module operand_fetch_scoreboard #(parameter int AW = 6) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] q1_idx,
  input  logic [AW-1:0] q2_idx,
  input  logic [AW-1:0] qd_idx,
  output logic          q1_busy,
  output logic          q2_busy,
  output logic          qd_busy
);
  logic [(1<<AW)-1:0] busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      // later assignment wins, giving set priority over clear
      if (set_en) busy[set_idx] <= 1'b1;
    end
  end

  assign q1_busy = busy[q1_idx];
  assign q2_busy = busy[q2_idx];
  assign qd_busy = busy[qd_idx];
endmodule

// File: rtl/regfile.sv
// Register file with asynchronous dual read and synchronous single write.
module regfile #(parameter int AW = 6, parameter int DW = 32) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2
);
  logic [DW-1:0] mem [1<<AW];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
endmodule

// File: rtl/operand_fetch.sv
// Issue stage: single-entry hold slot, scoreboard hazard stall, writeback forwarding,
// registered operand bundle toward execute.
module operand_fetch import operand_fetch_pkg::*; #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic       clk,
  input  logic       reset,
  operand_fetch_if.slave bus
);
  logic          h_full;
  logic [DW-1:0] h_instr;

  logic [5:0]    op;
  logic [AW-1:0] rd, rs1, rs2;
  logic [DW-1:0] imm;
  op_class_t     cls;

  assign op  = h_instr[OP_LO +: 6];
  assign rd  = h_instr[RD_LO +: AW];
  assign rs1 = h_instr[RS1_LO +: AW];
  assign rs2 = h_instr[RS2_LO +: AW];
  assign imm = {{(DW-IMM_W){h_instr[IMM_W-1]}}, h_instr[IMM_W-1:0]};
  assign cls = decode_class(op);

  logic sb1, sb2, sbd;
  logic fwd1, fwd2, fwdd;
  logic hazard, issue, accept;
  logic out_valid;

  operand_fetch_scoreboard #(.AW(AW)) u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (issue && cls.wr),
    .set_idx (rd),
    .clr_en  (bus.wb_we),
    .clr_idx (bus.wb_wa),
    .q1_idx  (rs1),
    .q2_idx  (rs2),
    .qd_idx  (rd),
    .q1_busy (sb1),
    .q2_busy (sb2),
    .qd_busy (sbd)
  );

  // a writeback landing this cycle both forwards data and releases the stall
  assign fwd1 = bus.wb_we && (bus.wb_wa == rs1);
  assign fwd2 = bus.wb_we && (bus.wb_wa == rs2);
  assign fwdd = bus.wb_we && (bus.wb_wa == rd);

  assign hazard = (cls.use1 && sb1 && !fwd1) ||
                  (cls.use2 && sb2 && !fwd2) ||
                  (cls.wr   && sbd && !fwdd);
  assign issue  = h_full && !hazard && (!out_valid || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;

  assign bus.in_ready = !h_full || issue;
  assign bus.addr1    = rs1;
  assign bus.addr2    = rs2;

  logic [DW-1:0] opnd_a, opnd_b;
  always_comb begin
    opnd_a = '0;
    opnd_b = '0;
    if (cls.use1) opnd_a = fwd1 ? bus.wb_wd : bus.reg1;
    if (cls.use2) opnd_b = fwd2 ? bus.wb_wd : bus.reg2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_full  <= 1'b0;
      h_instr <= '0;
    end else if (accept) begin
      h_full  <= 1'b1;
      h_instr <= bus.in_instr;
    end else if (issue) begin
      h_full  <= 1'b0;
    end
  end

  logic [5:0]    out_op;
  logic [AW-1:0] out_rd;
  logic [DW-1:0] out_a, out_b, out_imm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_rd    <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_imm   <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_op    <= cls.known ? op : OP_NOP;
      out_rd    <= rd;
      out_a     <= opnd_a;
      out_b     <= opnd_b;
      out_imm   <= imm;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_op    = out_op;
  assign bus.out_rd    = out_rd;
  assign bus.out_a     = out_a;
  assign bus.out_b     = out_b;
  assign bus.out_imm   = out_imm;
endmodule
